cop0: RTL and testbench

COP0 -- requirements
Module: cop0

---
 rtl/cop0_pkg.sv | 44 ++++
 rtl/cop0_if.sv | 31 +++
 rtl/cop0.sv | 128 ++++++++++++
 tb/tb_cop0.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cop0_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cop0_pkg
// Description : Shared encodings for the coprocessor-0 block: operation codes,
//               register numbers, exception codes and the EXL state type.
// Revision    : 1.0 - initial release
// ============================================================================
package cop0_pkg;

    localparam logic [2:0] COP_OP_NONE = 3'b000;
    localparam logic [2:0] COP_OP_SYS  = 3'b001;
    localparam logic [2:0] COP_OP_BRK  = 3'b010;
    localparam logic [2:0] COP_OP_RET  = 3'b011;
    localparam logic [2:0] COP_OP_MV   = 3'b100;
    localparam logic [2:0] COP_OP_EN   = 3'b101;
    localparam logic [2:0] COP_OP_DIS  = 3'b110;

    localparam logic [4:0] REG_STATUS  = 5'd12;
    localparam logic [4:0] REG_CAUSE   = 5'd13;
    localparam logic [4:0] REG_EPC     = 5'd14;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_SYS     = 5'd8;
    localparam logic [4:0] EXC_BRK     = 5'd9;

    // The architectural state is exactly Status.EXL.
    typedef enum logic {
        ST_NORMAL = 1'b0,
        ST_EXC    = 1'b1
    } cop0_state_e;

    function automatic logic [31:0] pack_status(input logic [5:0] im,
                                                input logic       exl,
                                                input logic       ie);
        return {16'h0000, im, 8'h00, exl, ie};
    endfunction

    function automatic logic [31:0] pack_cause(input logic [5:0] ip,
                                               input logic [4:0] exccode);
        return {16'h0000, ip, 3'b000, exccode, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/cop0_if.sv
`default_nettype none
// ============================================================================
// Module      : cop0_if
// Description : Pipeline-to-COP0 bus: decoded operation, operands, interrupt
//               lines and the results returned to writeback and the PC mux.
// Revision    : 1.0 - initial release
// ============================================================================
interface cop0_if;
    logic        ins_valid;
    logic [2:0]  cop0_op;
    logic        cop0_rd;
    logic        cop0_wr;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [5:0]  hw_int;
    logic [31:0] rdata;
    logic [31:0] pc_cop0;
    logic        exc_take;

    modport master (
        output ins_valid, cop0_op, cop0_rd, cop0_wr, rd, wdata, pc, hw_int,
        input  rdata, pc_cop0, exc_take
    );

    modport slave (
        input  ins_valid, cop0_op, cop0_rd, cop0_wr, rd, wdata, pc, hw_int,
        output rdata, pc_cop0, exc_take
    );
endinterface
`default_nettype wire

// File: rtl/cop0.sv
`default_nettype none
// ============================================================================
// Module      : cop0
// Description : Coprocessor 0 with Status/Cause/EPC, interrupt and syscall/
//               break entry, eret, mtc0/mfc0 and ei/di.
// Revision    : 1.0 - initial release
// ============================================================================
module cop0
    import cop0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  wire logic clk,
    input  wire logic rst,
    cop0_if.slave     bus
);

    logic        ie_q, ie_d;
    cop0_state_e state_q, state_d;
    logic [5:0]  im_q, im_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [5:0]  ip_q, ip_d;
    logic [31:0] epc_q, epc_d;

    logic [31:0] w_status;
    logic [31:0] w_cause;
    logic [31:0] w_reg_rd;
    logic        w_int_pend;
    logic        w_is_sys;
    logic        w_take_int;
    logic        w_take_sys;
    logic        w_lose;
    logic        w_eret;
    logic        w_mtc0;
    logic        w_mfc0;
    logic        w_ei;
    logic        w_di;
    logic        w_exc_take;

    always_comb begin
        w_status   = pack_status(im_q, state_q == ST_EXC, ie_q);
        w_cause    = pack_cause(ip_q, exccode_q);
        w_int_pend = ie_q && (state_q == ST_NORMAL) && (|(ip_q & im_q));
        w_is_sys   = (bus.cop0_op == COP_OP_SYS) || (bus.cop0_op == COP_OP_BRK);

        w_take_int = bus.ins_valid && w_int_pend;
        w_take_sys = bus.ins_valid && !w_int_pend && w_is_sys;
        // Anything below syscall/break in priority is squashed by these.
        w_lose     = !bus.ins_valid || w_int_pend || w_is_sys;
        w_eret     = !w_lose && (bus.cop0_op == COP_OP_RET);
        w_mtc0     = !w_lose && (bus.cop0_op == COP_OP_MV) && bus.cop0_rd;
        w_ei       = !w_lose && (bus.cop0_op == COP_OP_EN);
        w_di       = !w_lose && (bus.cop0_op == COP_OP_DIS);
        w_mfc0     = (bus.cop0_op == COP_OP_MV) && bus.cop0_wr;

        case (bus.rd)
            REG_STATUS: w_reg_rd = w_status;
            REG_CAUSE:  w_reg_rd = w_cause;
            REG_EPC:    w_reg_rd = epc_q;
            default:    w_reg_rd = 32'h0000_0000;
        endcase

        ie_d      = ie_q;
        state_d   = state_q;
        im_d      = im_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        ip_d      = bus.hw_int;

        if (w_take_int || w_take_sys) begin
            epc_d   = bus.pc;
            state_d = ST_EXC;
            if (w_take_int) begin
                exccode_d = EXC_INT;
            end else if (bus.cop0_op == COP_OP_BRK) begin
                exccode_d = EXC_BRK;
            end else begin
                exccode_d = EXC_SYS;
            end
        end else if (w_eret) begin
            state_d = ST_NORMAL;
        end else if (w_mtc0) begin
            case (bus.rd)
                REG_STATUS: begin
                    ie_d    = bus.wdata[0];
                    state_d = bus.wdata[1] ? ST_EXC : ST_NORMAL;
                    im_d    = bus.wdata[15:10];
                end
                REG_CAUSE:  exccode_d = bus.wdata[6:2];
                REG_EPC:    epc_d     = bus.wdata;
                default:    ;
            endcase
        end else if (w_ei) begin
            ie_d = 1'b1;
        end else if (w_di) begin
            ie_d = 1'b0;
        end

        w_exc_take = !rst && (w_take_int || w_take_sys);
    end

    assign bus.exc_take = w_exc_take;
    assign bus.pc_cop0  = w_exc_take ? EXC_VECTOR : epc_q;
    assign bus.rdata    = rst    ? 32'h0000_0000 :
                          w_mfc0 ? w_reg_rd :
                          ((bus.cop0_op == COP_OP_EN) || (bus.cop0_op == COP_OP_DIS)) ? w_status :
                          32'h0000_0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q      <= 1'b0;
            state_q   <= ST_NORMAL;
            im_q      <= 6'h00;
            exccode_q <= 5'h00;
            ip_q      <= 6'h00;
            epc_q     <= 32'h0000_0000;
        end else begin
            ie_q      <= ie_d;
            state_q   <= state_d;
            im_q      <= im_d;
            exccode_q <= exccode_d;
            ip_q      <= ip_d;
            epc_q     <= epc_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cop0.sv
`default_nettype none
// ============================================================================
// Module      : tb_cop0
// Description : Self-checking bench for cop0: directed scenarios plus a
//               randomized run against a word-level register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cop0;
    import cop0_pkg::*;

    localparam logic [31:0] C_VEC = 32'h0000_0180;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    cop0_if bus ();

    cop0 #(.EXC_VECTOR(C_VEC)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Model state kept as whole architectural words.
    logic [31:0] m_s, m_c, m_e;

    task automatic set_in(input logic v, input logic [2:0] op, input logic crd,
                          input logic cwr, input logic [4:0] r, input logic [31:0] wd,
                          input logic [31:0] p, input logic [5:0] hw);
        bus.ins_valid = v;
        bus.cop0_op   = op;
        bus.cop0_rd   = crd;
        bus.cop0_wr   = cwr;
        bus.rd        = r;
        bus.wdata     = wd;
        bus.pc        = p;
        bus.hw_int    = hw;
        #4;
    endtask

    task automatic cyc_end;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd12) return m_s;
        if (r == 5'd13) return m_c;
        if (r == 5'd14) return m_e;
        return 32'h0;
    endfunction

    task automatic test_reset;
        logic [4:0] regs [3] = '{5'd12, 5'd13, 5'd14};
        rst = 1'b1;
        set_in(1, COP_OP_SYS, 0, 0, 5'd0, 32'h0, 32'h100, 6'h3F);
        n_tests++;
        if (bus.exc_take !== 1'b0) begin
            n_fail++; $display("FAIL reset_exc_take got=%b exp=0", bus.exc_take);
        end
        cyc_end();
        set_in(1, COP_OP_MV, 0, 1, 5'd12, 32'h0, 32'h0, 6'h00);
        n_tests++;
        if (bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata);
        end
        cyc_end();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1, COP_OP_MV, 0, 1, regs[i], 32'h0, 32'h0, 6'h00);
            n_tests++;
            if (bus.rdata !== 32'h0) begin
                n_fail++; $display("FAIL reset_reg%0d got=%h exp=0", regs[i], bus.rdata);
            end
            cyc_end();
        end
    endtask

    task automatic test_mtc0_mfc0;
        set_in(1, COP_OP_MV, 1, 1, 5'd12, 32'h0000_0401, 32'h0, 6'h00);
        n_tests++;
        if (bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL mtc0_same_cycle got=%h exp=0", bus.rdata);
        end
        cyc_end();
        set_in(1, COP_OP_MV, 0, 1, 5'd12, 32'h0, 32'h0, 6'h00);
        n_tests++;
        if (bus.rdata !== 32'h0000_0401) begin
            n_fail++; $display("FAIL mfc0_status got=%h exp=00000401", bus.rdata);
        end
        cyc_end();
        set_in(1, COP_OP_MV, 1, 0, 5'd13, 32'hFFFF_FFFF, 32'h0, 6'h00);
        cyc_end();
        set_in(1, COP_OP_MV, 1, 0, 5'd7, 32'hFFFF_FFFF, 32'h0, 6'h00);
        cyc_end();
        set_in(1, COP_OP_MV, 0, 1, 5'd13, 32'h0, 32'h0, 6'h00);
        n_tests++;
        if (bus.rdata !== 32'h0000_007C) begin
            n_fail++; $display("FAIL mfc0_cause_mask got=%h exp=0000007c", bus.rdata);
        end
        cyc_end();
        set_in(1, COP_OP_MV, 0, 1, 5'd7, 32'h0, 32'h0, 6'h00);
        n_tests++;
        if (bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL mfc0_unimpl got=%h exp=0", bus.rdata);
        end
        cyc_end();
        set_in(1, COP_OP_MV, 1, 0, 5'd12, 32'h0, 32'h0, 6'h00);
        cyc_end();
    endtask

    task automatic test_syscall_eret;
        logic [4:0]  regs [3] = '{5'd12, 5'd13, 5'd14};
        logic [31:0] exp  [3] = '{32'h2, 32'h20, 32'h3010};
        set_in(1, COP_OP_SYS, 0, 0, 5'd0, 32'h0, 32'h0000_3010, 6'h00);
        n_tests++;
        if (bus.exc_take !== 1'b1 || bus.pc_cop0 !== C_VEC) begin
            n_fail++; $display("FAIL syscall_take got=%b/%h exp=1/%h", bus.exc_take, bus.pc_cop0, C_VEC);
        end
        cyc_end();
        for (int i = 0; i < 3; i++) begin
            set_in(1, COP_OP_MV, 0, 1, regs[i], 32'h0, 32'h0, 6'h00);
            n_tests++;
            if (bus.rdata !== exp[i]) begin
                n_fail++; $display("FAIL syscall_reg%0d got=%h exp=%h", regs[i], bus.rdata, exp[i]);
            end
            cyc_end();
        end
        set_in(1, COP_OP_RET, 0, 0, 5'd0, 32'h0, 32'h0000_0200, 6'h00);
        n_tests++;
        if (bus.pc_cop0 !== 32'h0000_3010 || bus.exc_take !== 1'b0) begin
            n_fail++; $display("FAIL eret_pc got=%h/%b exp=00003010/0", bus.pc_cop0, bus.exc_take);
        end
        cyc_end();
        set_in(1, COP_OP_MV, 0, 1, 5'd12, 32'h0, 32'h0, 6'h00);
        n_tests++;
        if (bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL eret_exl got=%h exp=0", bus.rdata);
        end
        cyc_end();
    endtask

    task automatic test_interrupt;
        logic [4:0]  regs [3] = '{5'd12, 5'd13, 5'd14};
        logic [31:0] exp  [3] = '{32'h403, 32'h400, 32'h5000};
        set_in(1, COP_OP_MV, 1, 0, 5'd12, 32'h0000_0401, 32'h0, 6'h00);
        cyc_end();
        set_in(1, COP_OP_NONE, 0, 0, 5'd0, 32'h0, 32'h4FFC, 6'h01);
        n_tests++;
        if (bus.exc_take !== 1'b0) begin
            n_fail++; $display("FAIL int_early got=%b exp=0", bus.exc_take);
        end
        cyc_end();
        set_in(1, COP_OP_NONE, 0, 0, 5'd0, 32'h0, 32'h5000, 6'h01);
        n_tests++;
        if (bus.exc_take !== 1'b1 || bus.pc_cop0 !== C_VEC) begin
            n_fail++; $display("FAIL int_take got=%b/%h exp=1/%h", bus.exc_take, bus.pc_cop0, C_VEC);
        end
        cyc_end();
        for (int i = 0; i < 3; i++) begin
            set_in(1, COP_OP_MV, 0, 1, regs[i], 32'h0, 32'h0, 6'h01);
            n_tests++;
            if (bus.rdata !== exp[i] || bus.exc_take !== 1'b0) begin
                n_fail++; $display("FAIL int_reg%0d got=%h/%b exp=%h/0", regs[i], bus.rdata, bus.exc_take, exp[i]);
            end
            cyc_end();
        end
        set_in(1, COP_OP_MV, 1, 0, 5'd12, 32'h0, 32'h0, 6'h00);
        cyc_end();
    endtask

    task automatic test_int_vs_break;
        set_in(1, COP_OP_MV, 1, 0, 5'd12, 32'h0000_0401, 32'h0, 6'h01);
        cyc_end();
        set_in(1, COP_OP_BRK, 0, 0, 5'd0, 32'h0, 32'h0000_4444, 6'h01);
        n_tests++;
        if (bus.exc_take !== 1'b1) begin
            n_fail++; $display("FAIL intbrk_take got=%b exp=1", bus.exc_take);
        end
        cyc_end();
        set_in(1, COP_OP_MV, 0, 1, 5'd13, 32'h0, 32'h0, 6'h01);
        n_tests++;
        if (bus.rdata !== 32'h0000_0400) begin
            n_fail++; $display("FAIL intbrk_cause got=%h exp=00000400", bus.rdata);
        end
        cyc_end();
        set_in(1, COP_OP_MV, 0, 1, 5'd14, 32'h0, 32'h0, 6'h01);
        n_tests++;
        if (bus.rdata !== 32'h0000_4444) begin
            n_fail++; $display("FAIL intbrk_epc got=%h exp=00004444", bus.rdata);
        end
        cyc_end();
        set_in(1, COP_OP_MV, 1, 0, 5'd12, 32'h0, 32'h0, 6'h00);
        cyc_end();
    endtask

    task automatic test_ei_reset;
        logic [4:0] regs [3] = '{5'd12, 5'd13, 5'd14};
        set_in(1, COP_OP_EN, 0, 0, 5'd0, 32'h0, 32'h0, 6'h00);
        n_tests++;
        if (bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL ei_rdata got=%h exp=0", bus.rdata);
        end
        cyc_end();
        set_in(1, COP_OP_DIS, 0, 0, 5'd0, 32'h0, 32'h0, 6'h00);
        n_tests++;
        if (bus.rdata !== 32'h1) begin
            n_fail++; $display("FAIL ei_ie got=%h exp=1", bus.rdata);
        end
        cyc_end();
        set_in(1, COP_OP_MV, 0, 1, 5'd12, 32'h0, 32'h0, 6'h00);
        n_tests++;
        if (bus.rdata !== 32'h0) begin
            n_fail++; $display("FAIL di_ie got=%h exp=0", bus.rdata);
        end
        cyc_end();
        set_in(1, COP_OP_SYS, 0, 0, 5'd0, 32'h0, 32'h0000_7000, 6'h00);
        cyc_end();
        rst = 1'b1;
        set_in(1, COP_OP_SYS, 0, 0, 5'd0, 32'h0, 32'h0000_7004, 6'h00);
        n_tests++;
        if (bus.exc_take !== 1'b0) begin
            n_fail++; $display("FAIL rst_exc_take got=%b exp=0", bus.exc_take);
        end
        cyc_end();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1, COP_OP_MV, 0, 1, regs[i], 32'h0, 32'h0, 6'h00);
            n_tests++;
            if (bus.rdata !== 32'h0) begin
                n_fail++; $display("FAIL rst_reg%0d got=%h exp=0", regs[i], bus.rdata);
            end
            cyc_end();
        end
    endtask

    task automatic test_random;
        logic        v, crd, cwr, pend, take;
        logic [2:0]  op;
        logic [4:0]  r;
        logic [31:0] wd, p, exp_rd;
        logic [5:0]  hw;
        logic [4:0]  sel [4] = '{5'd12, 5'd13, 5'd14, 5'd3};
        rst = 1'b1;
        set_in(0, COP_OP_NONE, 0, 0, 5'd0, 32'h0, 32'h0, 6'h00);
        cyc_end();
        rst = 1'b0;
        m_s = 32'h0; m_c = 32'h0; m_e = 32'h0;
        for (int n = 0; n < 400; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            op  = 3'($urandom_range(0, 6));
            crd = 1'($urandom);
            cwr = 1'($urandom);
            r   = sel[$urandom_range(0, 3)];
            wd  = $urandom;
            p   = $urandom & 32'hFFFF_FFFC;
            hw  = ($urandom_range(0, 5) == 0) ? 6'($urandom) : 6'h00;
            set_in(v, op, crd, cwr, r, wd, p, hw);

            pend = m_s[0] && !m_s[1] && ((m_c[15:10] & m_s[15:10]) != 6'h0);
            take = v && (pend || op == COP_OP_SYS || op == COP_OP_BRK);
            if (op == COP_OP_MV && cwr)                    exp_rd = m_read(r);
            else if (op == COP_OP_EN || op == COP_OP_DIS)  exp_rd = m_s;
            else                                           exp_rd = 32'h0;

            n_tests++;
            if (bus.exc_take !== take) begin
                n_fail++; $display("FAIL rand_exc_take n=%0d got=%b exp=%b", n, bus.exc_take, take);
            end
            if (v) begin
                n_tests++;
                if (bus.rdata !== exp_rd) begin
                    n_fail++; $display("FAIL rand_rdata n=%0d got=%h exp=%h", n, bus.rdata, exp_rd);
                end
            end
            if (take || (v && op == COP_OP_RET)) begin
                n_tests++;
                if (bus.pc_cop0 !== (take ? C_VEC : m_e)) begin
                    n_fail++; $display("FAIL rand_pc_cop0 n=%0d got=%h exp=%h", n, bus.pc_cop0, take ? C_VEC : m_e);
                end
            end

            if (v) begin
                if (take) begin
                    m_e = p;
                    m_s = m_s | 32'h2;
                    m_c = (m_c & ~32'h7C) |
                          (pend ? 32'h0 : ((op == COP_OP_BRK) ? 32'd9 << 2 : 32'd8 << 2));
                end else if (op == COP_OP_RET) begin
                    m_s = m_s & ~32'h2;
                end else if (op == COP_OP_MV && crd) begin
                    if (r == 5'd12)      m_s = wd & 32'h0000_FC03;
                    else if (r == 5'd13) m_c = (m_c & ~32'h7C) | (wd & 32'h7C);
                    else if (r == 5'd14) m_e = wd;
                end else if (op == COP_OP_EN) begin
                    m_s = m_s | 32'h1;
                end else if (op == COP_OP_DIS) begin
                    m_s = m_s & ~32'h1;
                end
            end
            m_c = (m_c & ~32'hFC00) | (32'(hw) << 10);
            cyc_end();
        end
    endtask

    initial begin
        set_in(0, COP_OP_NONE, 0, 0, 5'd0, 32'h0, 32'h0, 6'h00);
        cyc_end();
        test_reset();
        test_mtc0_mfc0();
        test_syscall_eret();
        test_interrupt();
        test_int_vs_break();
        test_ei_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
